multiport_register_file: RTL and testbench

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

---
 rtl/multiport_register_file.sv | 140 ++++++++++++++
 tb/tb_multiport_register_file.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_register_file.sv
`default_nettype none
// ============================================================================
// multiport_register_file
//   Multi-write / multi-read register file. Clear and reset zero every cell
//   through a pointer sweep. Optional macro REGISTER_FILE_BYPASS_EN enables
//   write-to-read forwarding.
// Revision: 1.0
// ============================================================================
module multiport_register_file #(
   parameter int N_BIT_DATA    = 16,
   parameter int N_BIT_ADDRESS = 16,
   parameter int N_WRITE       = 4,
   parameter int N_READ        = 16
) (
   input  logic                                        clock,
   input  logic                                        reset_n,
   input  logic [N_WRITE-1:0]                          write,
   input  logic [N_WRITE-1:0][N_BIT_ADDRESS-1:0]       address_write,
   input  logic [N_WRITE-1:0][N_BIT_DATA-1:0]          data_in,
   input  logic [N_READ-1:0]                           read,
   input  logic [N_READ-1:0][N_BIT_ADDRESS-1:0]        address_read,
   output logic [N_READ-1:0][N_BIT_DATA-1:0]           data_out,
   output logic [N_READ-1:0]                           read_valid,
   input  logic                                        clear,
   output logic                                        busy,
   output logic                                        write_conflict
);

   localparam int N_CELLS = 2**N_BIT_ADDRESS;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SWEEP = 1'b1
   } state_t;

   state_t                                state;
   state_t                                state_next;
   logic [N_BIT_ADDRESS-1:0]              ptr;
   logic [N_BIT_ADDRESS-1:0]              ptr_next;
   logic [N_BIT_DATA-1:0]                 mem [N_CELLS];
   logic                                  write_ok;
   logic                                  conflict;
   logic [N_READ-1:0][N_BIT_DATA-1:0]     rd_data;

   assign busy     = (state == SWEEP);
   // A clear request takes priority over writes presented in the same cycle.
   assign write_ok = (state == IDLE) && !clear;

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      case (state)
         IDLE: begin
            if (clear) begin
               state_next = SWEEP;
               ptr_next   = '0;
            end
         end
         SWEEP: begin
            ptr_next = ptr + 1'b1;
            if (ptr == {N_BIT_ADDRESS{1'b1}}) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = SWEEP;
            ptr_next   = '0;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= SWEEP;
         ptr   <= '0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
      end
   end

   always_comb begin
      conflict = 1'b0;
      for (int i = 0; i < N_WRITE; i++) begin
         for (int k = i + 1; k < N_WRITE; k++) begin
            if (write[i] && write[k] && (address_write[i] == address_write[k])) begin
               conflict = 1'b1;
            end
         end
      end
   end

   // Ascending channel order makes the highest-index writer win on a shared address.
   always_ff @(posedge clock) begin
      if (reset_n) begin
         if (state == SWEEP) begin
            mem[ptr] <= '0;
         end else if (write_ok) begin
            for (int i = 0; i < N_WRITE; i++) begin
               if (write[i]) begin
                  mem[address_write[i]] <= data_in[i];
               end
            end
         end
      end
   end

   always_comb begin
      for (int j = 0; j < N_READ; j++) begin
         rd_data[j] = mem[address_read[j]];
`ifdef REGISTER_FILE_BYPASS_EN
         for (int i = 0; i < N_WRITE; i++) begin
            if (write_ok && write[i] && (address_write[i] == address_read[j])) begin
               rd_data[j] = data_in[i];
            end
         end
`endif
      end
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         data_out       <= '0;
         read_valid     <= '0;
         write_conflict <= 1'b0;
      end else begin
         write_conflict <= conflict && write_ok;
         for (int j = 0; j < N_READ; j++) begin
            if (read[j] && !busy) begin
               data_out[j]   <= rd_data[j];
               read_valid[j] <= 1'b1;
            end else begin
               read_valid[j] <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multiport_register_file.sv
`default_nettype none
// ============================================================================
// tb_multiport_register_file
//   Vector table plus read scoreboard for multiport_register_file (8/4/2/2).
// Revision: 1.0
// ============================================================================
module tb_multiport_register_file;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int NW = 2;
   localparam int NR = 2;

   logic                        clock = 1'b0;
   logic                        reset_n;
   logic [NW-1:0]               write;
   logic [NW-1:0][AW-1:0]       address_write;
   logic [NW-1:0][DW-1:0]       data_in;
   logic [NR-1:0]               read;
   logic [NR-1:0][AW-1:0]       address_read;
   logic [NR-1:0][DW-1:0]       data_out;
   logic [NR-1:0]               read_valid;
   logic                        clear;
   logic                        busy;
   logic                        write_conflict;

   multiport_register_file #(
      .N_BIT_DATA    (DW),
      .N_BIT_ADDRESS (AW),
      .N_WRITE       (NW),
      .N_READ        (NR)
   ) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .write          (write),
      .address_write  (address_write),
      .data_in        (data_in),
      .read           (read),
      .address_read   (address_read),
      .data_out       (data_out),
      .read_valid     (read_valid),
      .clear          (clear),
      .busy           (busy),
      .write_conflict (write_conflict)
   );

   always #5 clock = ~clock;

   typedef struct {
      int            ch;
      logic          valid;
      logic [DW-1:0] data;
   } sb_t;

   sb_t           sb_q[$];
   logic [DW-1:0] last_exp [NR];
   int            tests = 0;
   int            failed = 0;

   typedef struct {
      logic          w0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          w1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic [AW-1:0] ra0;
      logic [AW-1:0] ra1;
      logic          conf;
      logic [DW-1:0] e0;
      logic [DW-1:0] e1;
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic issue_read(input int ch, input logic [AW-1:0] addr, input logic exp_valid,
                             input logic [DW-1:0] exp_data);
      sb_t e;
      read[ch]         = 1'b1;
      address_read[ch] = addr;
      e.ch    = ch;
      e.valid = exp_valid;
      e.data  = exp_valid ? exp_data : last_exp[ch];
      if (exp_valid) last_exp[ch] = exp_data;
      sb_q.push_back(e);
   endtask

   task automatic expect_idle(input int ch);
      sb_t e;
      e.ch    = ch;
      e.valid = 1'b0;
      e.data  = last_exp[ch];
      sb_q.push_back(e);
   endtask

   // Advance one edge, retire scoreboard entries, return inputs to idle.
   task automatic tick();
      sb_t e;
      @(posedge clock);
      #1;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check($sformatf("read_valid[%0d]", e.ch), {31'b0, read_valid[e.ch]}, {31'b0, e.valid});
         check($sformatf("data_out[%0d]", e.ch), {24'b0, data_out[e.ch]}, {24'b0, e.data});
      end
      write         = '0;
      address_write = '0;
      data_in       = '0;
      read          = '0;
      address_read  = '0;
      clear         = 1'b0;
   endtask

   task automatic count_busy(input string name, input int expected);
      int n;
      n = 0;
      while (busy && n < 40) begin
         tick();
         n++;
      end
      check(name, n, expected);
   endtask

   initial begin
      logic [DW-1:0] bypass_exp;

      vecs[0] = '{1'b1, 4'd3,  8'hA5, 1'b1, 4'd7, 8'h5A, 4'd3,  4'd7, 1'b0, 8'hA5, 8'h5A};
      vecs[1] = '{1'b1, 4'd9,  8'h11, 1'b1, 4'd9, 8'h22, 4'd9,  4'd9, 1'b1, 8'h22, 8'h22};
      vecs[2] = '{1'b1, 4'd4,  8'h10, 1'b0, 4'd0, 8'h00, 4'd4,  4'd3, 1'b0, 8'h10, 8'hA5};
      vecs[3] = '{1'b0, 4'd0,  8'h00, 1'b1, 4'd12, 8'hC3, 4'd12, 4'd9, 1'b0, 8'hC3, 8'h22};
      vecs[4] = '{1'b1, 4'd15, 8'h7E, 1'b1, 4'd0, 8'h81, 4'd15, 4'd0, 1'b0, 8'h7E, 8'h81};

      reset_n = 1'b0;
      write = '0; address_write = '0; data_in = '0;
      read = '0; address_read = '0; clear = 1'b0;
      for (int c = 0; c < NR; c++) last_exp[c] = '0;

      tick();
      tick();
      check("reset busy", {31'b0, busy}, 32'd1);
      check("reset read_valid", {30'b0, read_valid}, 32'd0);
      check("reset data_out", {16'b0, data_out}, 32'd0);
      check("reset write_conflict", {31'b0, write_conflict}, 32'd0);

      reset_n = 1'b1;
      count_busy("reset sweep cycles", 16);

      for (int a = 0; a < 16; a += 2) begin
         issue_read(0, AW'(a), 1'b1, 8'h00);
         issue_read(1, AW'(a + 1), 1'b1, 8'h00);
         tick();
      end

      for (int v = 0; v < 5; v++) begin
         write[0] = vecs[v].w0; address_write[0] = vecs[v].a0; data_in[0] = vecs[v].d0;
         write[1] = vecs[v].w1; address_write[1] = vecs[v].a1; data_in[1] = vecs[v].d1;
         tick();
         check($sformatf("vec%0d write_conflict", v), {31'b0, write_conflict}, {31'b0, vecs[v].conf});
         issue_read(0, vecs[v].ra0, 1'b1, vecs[v].e0);
         issue_read(1, vecs[v].ra1, 1'b1, vecs[v].e1);
         tick();
         check($sformatf("vec%0d conflict pulse end", v), {31'b0, write_conflict}, 32'd0);
      end

      expect_idle(0);
      expect_idle(1);
      tick();

`ifdef REGISTER_FILE_BYPASS_EN
      bypass_exp = 8'h33;
`else
      bypass_exp = 8'h10;
`endif
      write[0] = 1'b1; address_write[0] = 4'd4; data_in[0] = 8'h33;
      issue_read(0, 4'd4, 1'b1, bypass_exp);
      issue_read(1, 4'd7, 1'b1, 8'h5A);
      tick();
      issue_read(0, 4'd4, 1'b1, 8'h33);
      tick();

      clear = 1'b1;
      write[0] = 1'b1; address_write[0] = 4'd2; data_in[0] = 8'hFF;
      tick();
      check("clear busy", {31'b0, busy}, 32'd1);
      check("clear write_conflict", {31'b0, write_conflict}, 32'd0);
      begin
         int n;
         n = 0;
         while (busy && n < 40) begin
            if (n == 0) issue_read(0, 4'd3, 1'b0, 8'h00);
            if (n == 4) clear = 1'b1;
            tick();
            n++;
         end
         check("clear sweep cycles", n, 16);
      end
      issue_read(0, 4'd2, 1'b1, 8'h00);
      issue_read(1, 4'd3, 1'b1, 8'h00);
      tick();

      write[1] = 1'b1; address_write[1] = 4'd5; data_in[1] = 8'h77;
      tick();
      clear = 1'b1;
      tick();
      for (int k = 0; k < 10; k++) tick();
      check("busy at ptr 10", {31'b0, busy}, 32'd1);
      reset_n = 1'b0;
      write[0] = 1'b1; address_write[0] = 4'd6; data_in[0] = 8'h99;
      tick();
      reset_n = 1'b1;
      for (int c = 0; c < NR; c++) last_exp[c] = '0;
      check("mid reset data_out", {16'b0, data_out}, 32'd0);
      count_busy("restart sweep cycles", 16);
      issue_read(0, 4'd5, 1'b1, 8'h00);
      issue_read(1, 4'd6, 1'b1, 8'h00);
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
`default_nettype wire
